// File: rtl/data_age_register.sv
// Four independent 2-entry lane FIFOs; every stored entry carries a saturating age.
// Latency: a push into an empty lane is visible at the head on the same edge, with age 0.
// Backpressure: in_ready depends on registered counts only; a push into a full lane is dropped and sets a sticky flag.

module data_age_lane #(
  parameter logic [7:0] AGE_SAT = 8'd255,
  parameter int         DEPTH   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  input  logic       pop_req,
  output logic       push_rdy,
  output logic       head_vld,
  output logic [7:0] head_dat,
  output logic [7:0] head_age,
  output logic [1:0] cnt,
  output logic       drop_flag
);

  typedef struct packed {
    logic [7:0] dat;
    logic [7:0] age;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  entry_t     ent0_q, ent1_q;
  entry_t     ent0_nxt, ent1_nxt;
  entry_t     new_ent;
  logic [1:0] cnt_q, cnt_nxt;
  logic       drop_q, drop_nxt;
  logic       push, pop;

  function automatic logic [7:0] age_inc(input logic [7:0] a);
    return (a >= AGE_SAT) ? AGE_SAT : a + 8'd1;
  endfunction

  assign push_rdy = (cnt_q < FULL_CNT);
  assign head_vld = (cnt_q != 2'd0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_req & head_vld;
  assign new_ent  = '{dat: push_dat, age: 8'd0};

  // Entry 0 is always the head; unused slots are held at zero.
  always_comb begin
    ent0_nxt = ent0_q;
    ent1_nxt = ent1_q;
    cnt_nxt  = cnt_q;
    drop_nxt = drop_q | (push_vld & ~push_rdy);
    case (cnt_q)
      2'd0: begin
        if (push) begin
          ent0_nxt = new_ent;
          cnt_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          ent0_nxt = new_ent;
        end else if (pop) begin
          ent0_nxt = '0;
          cnt_nxt  = 2'd0;
        end else if (push) begin
          ent0_nxt.age = age_inc(ent0_q.age);
          ent1_nxt     = new_ent;
          cnt_nxt      = 2'd2;
        end else begin
          ent0_nxt.age = age_inc(ent0_q.age);
        end
      end
      2'd2: begin
        if (pop) begin
          ent0_nxt = '{dat: ent1_q.dat, age: age_inc(ent1_q.age)};
          ent1_nxt = '0;
          cnt_nxt  = 2'd1;
        end else begin
          ent0_nxt.age = age_inc(ent0_q.age);
          ent1_nxt.age = age_inc(ent1_q.age);
        end
      end
      default: begin
        ent0_nxt = '0;
        ent1_nxt = '0;
        cnt_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
      drop_q <= 1'b0;
    end else begin
      ent0_q <= ent0_nxt;
      ent1_q <= ent1_nxt;
      cnt_q  <= cnt_nxt;
      drop_q <= drop_nxt;
    end
  end

  assign head_dat  = head_vld ? ent0_q.dat : 8'h00;
  assign head_age  = head_vld ? ent0_q.age : 8'h00;
  assign cnt       = cnt_q;
  assign drop_flag = drop_q;

endmodule

// Top: four aging lanes side by side, plus a total-occupancy count.
// Latency: same as a single lane; occupancy tracks the registered counts.
// Backpressure: per-lane in_ready, independent across lanes.
module data_age_register #(
  parameter logic [7:0] AGE_SAT = 8'd255,
  parameter int         DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  output logic [3:0]  in_ready,
  input  logic [3:0]  consume,
  output logic [3:0]  input_valid,
  output logic [31:0] age_of_data,
  output logic [31:0] input_data,
  output logic [3:0]  occupancy,
  output logic [3:0]  drop_flag
);

  logic [1:0] lane_cnt [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    data_age_lane #(
      .AGE_SAT (AGE_SAT),
      .DEPTH   (DEPTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .push_vld  (in_valid[i]),
      .push_dat  (in_data[8*i +: 8]),
      .pop_req   (consume[i]),
      .push_rdy  (in_ready[i]),
      .head_vld  (input_valid[i]),
      .head_dat  (input_data[8*i +: 8]),
      .head_age  (age_of_data[8*i +: 8]),
      .cnt       (lane_cnt[i]),
      .drop_flag (drop_flag[i])
    );
  end

  always_comb begin
    occupancy = 4'd0;
    for (int i = 0; i < 4; i++) begin
      occupancy = occupancy + {2'b00, lane_cnt[i]};
    end
  end

endmodule

// File: tb/tb_data_age_register.sv
// Directed bench for data_age_register: hand-computed expectations for fill, aging, order, edge cases and async reset.
module tb_data_age_register;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  consume;
  logic [3:0]  input_valid;
  logic [31:0] age_of_data;
  logic [31:0] input_data;
  logic [3:0]  occupancy;
  logic [3:0]  drop_flag;

  int n_checks = 0;
  int n_fail   = 0;

  data_age_register dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .consume     (consume),
    .input_valid (input_valid),
    .age_of_data (age_of_data),
    .input_data  (input_data),
    .occupancy   (occupancy),
    .drop_flag   (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive for one rising edge, then idle and return at the next falling edge.
  task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic [3:0] c);
    in_valid = v;
    in_data  = d;
    consume  = c;
    @(negedge clk);
    in_valid = 4'h0;
    in_data  = 32'h0;
    consume  = 4'h0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_ivld"},  {28'h0, input_valid}, 32'h0);
    chk({tag, "_age"},   age_of_data, 32'h0);
    chk({tag, "_data"},  input_data, 32'h0);
    chk({tag, "_occ"},   {28'h0, occupancy}, 32'h0);
    chk({tag, "_drop"},  {28'h0, drop_flag}, 32'h0);
    chk({tag, "_rdy"},   {28'h0, in_ready}, 32'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    in_valid = 4'h0;
    in_data  = 32'h0;
    consume  = 4'h0;
    #12;
    reset_outputs("rst");

    // Fill all four lanes on the first edge out of reset.
    @(negedge clk);
    reset = 1'b1;
    cyc(4'hF, 32'hD4B2C3A1, 4'h0);
    chk("fill_ivld", {28'h0, input_valid}, 32'hF);
    chk("fill_data", input_data, 32'hD4B2C3A1);
    chk("fill_age",  age_of_data, 32'h0);
    chk("fill_occ",  {28'h0, occupancy}, 32'd4);
    chk("fill_rdy",  {28'h0, in_ready}, 32'hF);

    for (int i = 0; i < 10; i++) cyc(4'h0, 32'h0, 4'h0);
    chk("age10", age_of_data, 32'h0A0A0A0A);
    for (int i = 0; i < 290; i++) cyc(4'h0, 32'h0, 4'h0);
    chk("age_sat", age_of_data, 32'hFFFFFFFF);
    chk("age_sat_data", input_data, 32'hD4B2C3A1);

    // Clean slate for ordering tests.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    cyc(4'h1, 32'h00000011, 4'h0);
    cyc(4'h1, 32'h00000022, 4'h0);
    chk("full_rdy", {28'h0, in_ready}, 32'hE);
    cyc(4'h1, 32'h00000033, 4'h0);
    chk("full_drop", {28'h0, drop_flag}, 32'h1);
    chk("full_head", input_data, 32'h00000011);
    chk("full_age",  age_of_data, 32'h00000002);
    chk("full_occ",  {28'h0, occupancy}, 32'd2);
    // Pop on a full lane with a push on the same edge: pop wins, push refused.
    cyc(4'h1, 32'h00000044, 4'h1);
    chk("pop_head", input_data, 32'h00000022);
    chk("pop_age",  age_of_data, 32'h00000002);
    chk("pop_occ",  {28'h0, occupancy}, 32'd1);
    chk("pop_rdy",  {28'h0, in_ready}, 32'hF);
    chk("pop_drop", {28'h0, drop_flag}, 32'h1);

    // Lane 2: push+pop on a single-entry lane swaps in the new entry at age 0.
    cyc(4'h4, 32'h00550000, 4'h0);
    cyc(4'h0, 32'h0, 4'h0);
    chk("l2_age_before", age_of_data, 32'h00010004);
    cyc(4'h4, 32'h00660000, 4'h4);
    chk("l2_data", input_data, 32'h00660022);
    chk("l2_age",  age_of_data, 32'h00000005);
    chk("l2_occ",  {28'h0, occupancy}, 32'd2);

    cyc(4'h0, 32'h0, 4'hF);
    chk("drain_occ",  {28'h0, occupancy}, 32'd0);
    chk("drain_ivld", {28'h0, input_valid}, 32'h0);
    cyc(4'h0, 32'h0, 4'hF);
    chk("spur_occ",  {28'h0, occupancy}, 32'd0);
    chk("spur_data", input_data, 32'h0);
    chk("spur_age",  age_of_data, 32'h0);

    // Push and pop on an empty lane: the push lands.
    cyc(4'h2, 32'h00007700, 4'h2);
    chk("e_pp_data", input_data, 32'h00007700);
    chk("e_pp_occ",  {28'h0, occupancy}, 32'd1);

    cyc(4'hD, 32'hA3A2A1A0, 4'h0);
    cyc(4'h2, 32'h00008800, 4'h0);
    cyc(4'h2, 32'h00009900, 4'h0);
    chk("five_occ",  {28'h0, occupancy}, 32'd5);
    chk("five_drop", {28'h0, drop_flag}, 32'h3);
    chk("five_data", input_data, 32'hA3A277A0);
    chk("five_rdy",  {28'h0, in_ready}, 32'hD);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    reset_outputs("arst");
    // Held reset across an edge with requests pending: nothing registers.
    in_valid = 4'hF;
    in_data  = 32'h12345678;
    consume  = 4'hF;
    @(negedge clk);
    reset_outputs("arst_hold");
    in_valid = 4'h0;
    in_data  = 32'h0;
    consume  = 4'h0;
    reset = 1'b1;
    cyc(4'h8, 32'h5A000000, 4'h0);
    chk("post_rst_data", input_data, 32'h5A000000);
    chk("post_rst_occ",  {28'h0, occupancy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_age_register.md
DATA_AGE_REGISTER -- requirements
Module: data_age_register

Interface
REQ-001 Parameter: AGE_SAT, 8'd255, saturation value of every per-entry age counter.
REQ-002 Parameter: DEPTH, 2, entries per lane FIFO; only the value 2 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  4  per-lane write request; bit i belongs to lane i.
REQ-006 Port: in_data  input  32  write data; lane i occupies bits [8i+7:8i].
REQ-007 Port: in_ready  output  4  per-lane space available.
REQ-008 Port: consume  input  4  per-lane pop of the head entry, driven by the downstream ranking stage.
REQ-009 Port: input_valid  output  4  per-lane head entry valid, fed to the ranking stage.
REQ-010 Port: age_of_data  output  32  head-entry age; lane i occupies bits [8i+7:8i].
REQ-011 Port: input_data  output  32  head-entry data; lane i occupies bits [8i+7:8i].
REQ-012 Port: occupancy  output  4  total stored entries across all lanes, 0..8.
REQ-013 Port: drop_flag  output  4  sticky per-lane flag: a write was attempted while the lane was full.

Function
REQ-014 Each lane shall be an independent 2-entry FIFO; each entry holds 8-bit data and an 8-bit age.
REQ-015 in_ready[i] shall be 1 when lane i holds fewer than 2 entries.
REQ-016 in_ready[i] shall be a function of registered state only, with no combinational path from consume.
REQ-017 A push occurs on a rising edge with in_valid[i]=1 and in_ready[i]=1; the new entry's age is 0 after that edge.
REQ-018 A push attempt with in_ready[i]=0 shall discard the data and set drop_flag[i]; the flag stays set until reset.
REQ-019 A pop occurs on a rising edge with consume[i]=1 and input_valid[i]=1.
REQ-020 consume[i] while input_valid[i]=0 shall be ignored.
REQ-021 After a pop, the second entry (if any) shall become head, keeping its age and data.
REQ-022 On each rising edge, every stored entry that is not popped shall increment its age by 1, saturating at AGE_SAT.
REQ-023 Ages of different entries and lanes shall be independent.
REQ-024 Lane with 0 entries, simultaneous push and pop: the pop is ignored and the push succeeds.
REQ-025 Lane with 1 entry, simultaneous push and pop: the head leaves; the new entry becomes head with age 0; the count stays 1.
REQ-026 Lane with 2 entries: push is refused per REQ-018, even when a pop occurs on the same edge; the pop still succeeds.
REQ-027 input_valid[i] shall equal 1 when lane i is non-empty.
REQ-028 age_of_data and input_data lanes shall show the head entry; an empty lane shall drive 8'h00 on both.
REQ-029 All outputs shall be driven directly from registers, or from registered state through combinational logic only.
REQ-030 Latency: data pushed into an empty lane at edge N shall appear on input_data at edge N with input_valid=1 and age 0; it reads age k after edge N+k.
REQ-031 occupancy shall equal the sum of the four lane counts, updated on the same edge as the pushes and pops.

Reset
REQ-032 reset=0 shall immediately, without a clock, clear all entries, counts and ages.
REQ-033 During reset: input_valid=4'h0, age_of_data=32'h0, input_data=32'h0, occupancy=0, drop_flag=4'h0, in_ready=4'hF.
REQ-034 Reset asserted mid-operation shall discard all stored entries; no pop or push shall be registered on the edge where reset deasserts if reset is still low at that edge.
REQ-035 The first push shall be accepted on the first rising edge with reset=1.

Verification
REQ-036 Reset then fill: push in_data=32'hD4B2C3A1, in_valid=4'hF once -> input_valid=4'hF, input_data=32'hD4B2C3A1, age_of_data=32'h0, occupancy=4.
REQ-037 Aging: hold with no consume for 10 edges -> age_of_data=32'h0A0A0A0A; after 300 edges -> 32'hFFFFFFFF (saturation).
REQ-038 FIFO order/full: lane 0 push 8'h11 then 8'h22; third push 8'h33 -> in_ready[0]=0, drop_flag[0]=1. Consume lane 0 -> head 8'h22 with age 1 greater than its prior value.
REQ-039 Simultaneous on 1-entry lane: lane 2 holds 8'h55, push 8'h66 with consume[2]=1 -> head 8'h66, age 0, occupancy unchanged.
REQ-040 Spurious consume: consume=4'hF on an empty block -> no change, occupancy=0.
REQ-041 Async reset mid-stream: assert reset between edges with 5 entries stored -> outputs zero immediately, drop_flag cleared, in_ready=4'hF.
